// File: rtl/config_arb_pkg.sv
// Shared definitions for the NI configuration-bus arbiter.
// Contents:
//   CFG_ADDR_WIDTH / CFG_DATA_WIDTH : default config bus widths
//   BANK_MSB / BANK_LSB             : position of the 3-bit bank id inside the address
//   bank_e                          : config bank identifiers
//   access_t                        : one bus access (wr, addr, wdata)
//   idx_width()                     : width of an encoded requester index
package config_arb_pkg;

    localparam int unsigned CFG_ADDR_WIDTH = 14;
    localparam int unsigned CFG_DATA_WIDTH = 32;

    localparam int unsigned BANK_MSB = CFG_ADDR_WIDTH - 1;
    localparam int unsigned BANK_LSB = CFG_ADDR_WIDTH - 3;

    typedef enum logic [2:0] {
        BankDma     = 3'd0,
        BankSched   = 3'd1,
        BankTdm     = 3'd2,
        BankMc      = 3'd3,
        BankIrq     = 3'd4,
        BankDefault = 3'd7
    } bank_e;

    typedef struct packed {
        logic                      wr;
        logic [CFG_ADDR_WIDTH-1:0] addr;
        logic [CFG_DATA_WIDTH-1:0] wdata;
    } access_t;

    // At least one bit, so a single-requester index is still a legal vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req   : request vector
//   last  : index of the previous winner; search starts at last+1 (mod N)
//   mask  : eligibility mask (all ones normally, one-hot owner when locked)
//   grant : one-hot winner, zero when nothing eligible
//   idx   : encoded winner index (0 when no winner)
//   valid : a winner exists
module rr_picker
    import config_arb_pkg::*;
#(
    parameter int unsigned N = 3,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [N-1:0]  eligible;
    logic [IW-1:0] cand;

    assign eligible = req & mask;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        // Walk offsets 1..N so the previous winner is examined last.
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IW'((32'(last) + off) % N);
            if (!valid && eligible[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/config_arbiter.sv
// Round-robin arbiter sharing the NI configuration bus between N_REQ masters,
// with an ownership lock for atomic read-modify-write sequences.
// Ports:
//   clk, reset (async, active low)
//   req_en/req_wr/req_lock/req_addr/req_wdata : flattened per-requester commands
//   req_grant   : one-hot accept pulse, same cycle as the winning request
//   resp_valid  : one-hot response pulse two cycles after the grant
//   resp_rdata, resp_error : bus response routed back with resp_valid
//   config_*    : registered bus command / bus response inputs
module config_arbiter
    import config_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_en,
    input  logic [N_REQ-1:0]            req_wr,
    input  logic [N_REQ-1:0]            req_lock,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            req_grant,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]       resp_rdata,
    output logic                        resp_error,
    output logic [ADDR_WIDTH-1:0]       config_addr,
    output logic                        config_en,
    output logic                        config_wr,
    output logic [DATA_WIDTH-1:0]       config_wdata,
    input  logic [DATA_WIDTH-1:0]       config_rdata,
    input  logic                        config_error
);

    localparam int unsigned IW = idx_width(N_REQ);

    logic [IW-1:0]         last_q;
    logic                  has_winner_q;
    logic                  lock_q;
    logic [IW-1:0]         owner_q;
    logic [N_REQ-1:0]      issue_q;      // owner of the access currently on the bus

    logic [IW-1:0]         search_last;
    logic [N_REQ-1:0]      lock_mask;
    logic [N_REQ-1:0]      pick_grant;
    logic [IW-1:0]         pick_idx;
    logic                  pick_valid;

    logic                  sel_wr;
    logic                  sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Before the first grant after reset, pretend the last winner was N_REQ-1 so
    // the search starts at requester 0 while the stored pointer still reads 0.
    assign search_last = has_winner_q ? last_q : IW'(N_REQ - 1);

    always_comb begin
        lock_mask = '1;
        if (lock_q) begin
            lock_mask          = '0;
            lock_mask[owner_q] = 1'b1;
        end
    end

    rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .req   (req_en),
        .last  (search_last),
        .mask  (lock_mask),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_wr    = req_wr[i];
                sel_lock  = req_lock[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Keep grant quiet while reset is held so every output reads 0 in reset.
    assign req_grant = reset ? pick_grant : '0;

    // Bus response arrives combinationally in the cycle resp_valid is high.
    assign resp_rdata = (|resp_valid) ? config_rdata : '0;
    assign resp_error = (|resp_valid) ? config_error : 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q       <= '0;
            has_winner_q <= 1'b0;
            lock_q       <= 1'b0;
            owner_q      <= '0;
            issue_q      <= '0;
            resp_valid   <= '0;
            config_en    <= 1'b0;
            config_wr    <= 1'b0;
            config_addr  <= '0;
            config_wdata <= '0;
        end else begin
            config_en  <= pick_valid;
            issue_q    <= pick_grant;
            resp_valid <= issue_q;
            if (pick_valid) begin
                last_q       <= pick_idx;
                has_winner_q <= 1'b1;
                config_wr    <= sel_wr;
                config_addr  <= sel_addr;
                config_wdata <= sel_wdata;
                // While locked only the owner can win, so a lock=0 grant here is
                // either unlocked traffic or the owner's releasing access.
                lock_q       <= sel_lock;
                if (sel_lock) begin
                    owner_q <= pick_idx;
                end
            end
        end
    end

endmodule
